// File: rtl/inst_loader_if.sv
// Byte-stream handshake plus instruction-memory write port used by the boot loader.
// The loader sits on the slave side; the byte source and memory model sit on the master side.
interface inst_loader_if #(
    parameter int ADDR_WIDTH = 18
);
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/inst_loader.sv
// Boot-time instruction memory writer: frames a length-prefixed, XOR-checksummed byte
// stream into big-endian words and keeps the CPU frozen until the image is verified.
//
// state  | meaning
// S_LEN  | collecting the 4 length bytes (MSB first)
// S_DATA | assembling words and writing them to instruction memory
// S_CSUM | waiting for the checksum byte
// S_DONE | image loaded and verified; CPU released
// S_ERR  | length overflow or checksum mismatch; CPU held
module inst_loader #(
    parameter int          ADDR_WIDTH = 18,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic           i_clock,
    input  logic           i_reset,
    inst_loader_if.slave   bus,
    output logic           o_cpu_hold,
    output logic           o_pc_clear,
    output logic           o_load_done,
    output logic           o_load_err
);
    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Largest image that fits between BASE_ADDR and the top of memory without wrapping.
    localparam logic [32:0]           LP_MAX_WORDS = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LP_BASE      = ADDR_WIDTH'(BASE_ADDR);

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_byte_cnt;
    logic [31:0]           r_word_cnt;
    logic [31:0]           r_len;
    logic [23:0]           r_word;
    logic [7:0]            r_csum;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_wdata;
    logic                  r_pc_clear;

    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_last_byte;
    logic                  w_word_done;
    logic                  w_enter_done;
    logic [31:0]           w_len_full;
    logic [31:0]           w_word_full;
    logic [31:0]           w_word_cnt_inc;

    assign w_ready        = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_xfer         = bus.byte_valid && w_ready;
    assign w_last_byte    = (r_byte_cnt == 2'd3);
    assign w_len_full     = {r_len[23:0], bus.byte_in};
    assign w_word_full    = {r_word, bus.byte_in};
    assign w_word_cnt_inc = r_word_cnt + 32'd1;

    always_comb begin
        w_state_next = r_state;
        w_word_done  = 1'b0;
        w_enter_done = 1'b0;
        case (r_state)
            S_LEN: begin
                if (w_xfer && w_last_byte) begin
                    if ({1'b0, w_len_full} > LP_MAX_WORDS) begin
                        w_state_next = S_ERR;
                    end else if (w_len_full == 32'd0) begin
                        w_state_next = S_CSUM;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer && w_last_byte) begin
                    w_word_done = 1'b1;
                    if (w_word_cnt_inc == r_len) begin
                        w_state_next = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    if (bus.byte_in == r_csum) begin
                        w_state_next = S_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_next = S_ERR;
                    end
                end
            end
            S_DONE:  w_state_next = S_DONE;
            S_ERR:   w_state_next = S_ERR;
            default: w_state_next = S_ERR;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_LEN;
            r_byte_cnt   <= 2'd0;
            r_word_cnt   <= 32'd0;
            r_len        <= 32'd0;
            r_word       <= 24'd0;
            r_csum       <= 8'd0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= LP_BASE;
            r_imem_wdata <= 32'd0;
            r_pc_clear   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_imem_we  <= w_word_done;
            r_pc_clear <= w_enter_done;
            if (w_xfer) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_xfer && (r_state == S_LEN)) begin
                r_len <= w_len_full;
            end
            if (w_xfer && (r_state == S_DATA)) begin
                r_word <= w_word_full[23:0];
                r_csum <= r_csum ^ bus.byte_in;
            end
            // Write is issued the cycle after the 4th byte, so the port is registered.
            if (w_word_done) begin
                r_imem_wdata <= w_word_full;
                r_imem_addr  <= LP_BASE + r_word_cnt[ADDR_WIDTH-1:0];
                r_word_cnt   <= w_word_cnt_inc;
            end
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign o_cpu_hold     = (r_state != S_DONE);
    assign o_pc_clear     = r_pc_clear;
    assign o_load_done    = (r_state == S_DONE);
    assign o_load_err     = (r_state == S_ERR);
endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: table of frame scenarios, hand-written corner sequences,
// and random frames checked against a frame-level model of the loader.
module tb_inst_loader;
    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_hold, pc_clear, load_done, load_err;

    inst_loader_if #(.ADDR_WIDTH(AW)) bif();

    inst_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .bus        (bif.slave),
        .o_cpu_hold (cpu_hold),
        .o_pc_clear (pc_clear),
        .o_load_done(load_done),
        .o_load_err (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    int            pc_cnt = 0;
    int            pc_bad = 0;
    logic          prev_hold = 1'b1;

    always @(negedge clk) begin
        if (bif.imem_we === 1'b1) begin
            wr_addr_q.push_back(bif.imem_addr);
            wr_data_q.push_back(bif.imem_wdata);
        end
        if (pc_clear === 1'b1) begin
            pc_cnt++;
            if (!(prev_hold === 1'b1 && cpu_hold === 1'b0)) pc_bad++;
        end
        prev_hold = cpu_hold;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_sb();
        wr_addr_q.delete();
        wr_data_q.delete();
        pc_cnt = 0;
        pc_bad = 0;
    endtask

    task automatic do_reset();
        clear_sb();
        rst = 1'b1;
        bif.byte_valid = 1'b0;
        bif.byte_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_we",    64'(bif.imem_we),    64'd0);
        chk("rst_addr",  64'(bif.imem_addr),  64'd0);
        chk("rst_wdata", 64'(bif.imem_wdata), 64'd0);
        chk("rst_hold",  64'(cpu_hold),       64'd1);
        chk("rst_pcclr", 64'(pc_clear),       64'd0);
        chk("rst_done",  64'(load_done),      64'd0);
        chk("rst_err",   64'(load_err),       64'd0);
        chk("rst_ready", 64'(bif.byte_ready), 64'd1);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   t;
        bif.byte_in = b;
        bif.byte_valid = 1'b1;
        t = 0;
        forever begin
            rdy = bif.byte_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy === 1'b1) break;
            t++;
            if (t > 8) begin
                chk("accept", 64'd0, 64'd1);
                break;
            end
        end
        if (gap > 0) begin
            bif.byte_valid = 1'b0;
            bif.byte_in = 8'($urandom);
            repeat (gap) @(negedge clk);
        end
    endtask

    function automatic int pick_gap(input int gap, input bit rnd);
        return rnd ? int'($urandom_range(0, 3)) : gap;
    endfunction

    task automatic send_word(input logic [31:0] w, input int gap, input bit rnd);
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], pick_gap(gap, rnd));
    endtask

    task automatic send_frame(input logic [31:0] len, input logic [31:0] wq[$],
                              input bit send_cs, input logic [7:0] cs,
                              input int gap, input bit rnd);
        send_word(len, gap, rnd);
        foreach (wq[i]) send_word(wq[i], gap, rnd);
        if (send_cs) send_byte(cs, pick_gap(gap, rnd));
        bif.byte_valid = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input bit e_done, input bit e_err,
                                input logic [31:0] ew[$]);
        chk({tag, "_done"},  64'(load_done),        64'(e_done));
        chk({tag, "_err"},   64'(load_err),         64'(e_err));
        chk({tag, "_hold"},  64'(cpu_hold),         64'(!e_done));
        chk({tag, "_ready"}, 64'(bif.byte_ready),   64'd0);
        chk({tag, "_pcclr"}, 64'(pc_cnt),           64'(e_done));
        chk({tag, "_pchold"},64'(pc_bad),           64'd0);
        chk({tag, "_nwr"},   64'(wr_data_q.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size() && i < wr_data_q.size(); i++) begin
            chk({tag, "_addr"}, 64'(wr_addr_q[i]), 64'(i));
            chk({tag, "_data"}, 64'(wr_data_q[i]), 64'(ew[i]));
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nw;
        bit          send_cs;
        logic [7:0]  cs;
        int          gap;
        bit          e_done;
        bit          e_err;
        int          e_nwr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [31:0] wq[$];
        logic [31:0] ew[$];
        logic [7:0]  x;
        logic [7:0]  cs;
        bit          bad;
        int          n;

        tbl[0] = '{"two_word",  32'd2, 32'h20080005, 32'h2009000A, 2, 1'b1, 8'h0E, 0, 1'b1, 1'b0, 2};
        tbl[1] = '{"gaps",      32'd2, 32'h20080005, 32'h2009000A, 2, 1'b1, 8'h0E, 3, 1'b1, 1'b0, 2};
        tbl[2] = '{"zero_ok",   32'd0, 32'h0,        32'h0,        0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 0};
        tbl[3] = '{"zero_bad",  32'd0, 32'h0,        32'h0,        0, 1'b1, 8'h01, 0, 1'b0, 1'b1, 0};
        tbl[4] = '{"bad_csum",  32'd2, 32'h20080005, 32'h2009000A, 2, 1'b1, 8'h0F, 0, 1'b0, 1'b1, 2};
        tbl[5] = '{"overflow",  32'h00040001, 32'h0, 32'h0,        0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 0};

        bif.byte_valid = 1'b0;
        bif.byte_in = 8'h00;
        @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            do_reset();
            wq.delete();
            ew.delete();
            if (tbl[r].nw > 0) wq.push_back(tbl[r].w0);
            if (tbl[r].nw > 1) wq.push_back(tbl[r].w1);
            for (int i = 0; i < tbl[r].e_nwr; i++) ew.push_back(wq[i]);
            send_frame(tbl[r].len, wq, tbl[r].send_cs, tbl[r].cs, tbl[r].gap, 1'b0);
            check_result(tbl[r].name, tbl[r].e_done, tbl[r].e_err, ew);
        end

        // Overflow is flagged on the very cycle after the 4th length byte.
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h04, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        bif.byte_valid = 1'b0;
        chk("ovf_now_err",   64'(load_err),       64'd1);
        chk("ovf_now_ready", 64'(bif.byte_ready), 64'd0);

        // Largest legal image: accepted into DATA and writes start at address 0.
        do_reset();
        send_word(32'h00040000, 0, 1'b0);
        bif.byte_valid = 1'b0;
        @(negedge clk);
        chk("max_len_err",   64'(load_err),       64'd0);
        chk("max_len_ready", 64'(bif.byte_ready), 64'd1);
        chk("max_len_hold",  64'(cpu_hold),       64'd1);
        send_word(32'h12345678, 0, 1'b0);
        bif.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("max_len_nwr",  64'(wr_data_q.size()), 64'd1);
        if (wr_data_q.size() > 0) begin
            chk("max_len_data", 64'(wr_data_q[0]), 64'h12345678);
            chk("max_len_addr", 64'(wr_addr_q[0]), 64'd0);
        end

        // Reset mid-load, asserted together with the 4th byte of the first word.
        do_reset();
        send_word(32'd2, 0, 1'b0);
        send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0);
        bif.byte_in = 8'h05;
        bif.byte_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bif.byte_valid = 1'b0;
        @(negedge clk);
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        send_frame(32'd1, wq, 1'b1, 8'h22, 0, 1'b0);
        check_result("mid_reset", 1'b1, 1'b0, wq);

        // Random frames against a frame-level model.
        for (int f = 0; f < 25; f++) begin
            do_reset();
            n = int'($urandom_range(0, 6));
            wq.delete();
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                wq.push_back($urandom);
                x = x ^ wq[i][31:24] ^ wq[i][23:16] ^ wq[i][15:8] ^ wq[i][7:0];
            end
            bad = ($urandom_range(0, 3) == 0);
            cs = bad ? (x ^ 8'($urandom_range(1, 255))) : x;
            send_frame(32'(n), wq, 1'b1, cs, 0, 1'b1);
            check_result("rand", !bad, bad, wq);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time writer for the instruction memory; the write-side counterpart to the CPU fetch path, which only reads instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instructions.
- Writes each instruction through the instruction memory write port.
- Holds the pipeline frozen until the whole image has been loaded and its checksum verified.

Parameters:
ADDR_WIDTH  18  instruction memory word-address width (262144 words)
BASE_ADDR   0   word address that receives the first instruction

Ports:
clock       input   1   system clock; all state updates on its rising edge
reset       input   1   synchronous, active-high reset
byte_in     input   8   stream byte
byte_valid  input   1   byte_in holds a valid byte
byte_ready  output  1   loader can accept a byte; a transfer occurs when byte_valid && byte_ready at a clock edge
imem_we     output  1   instruction memory write enable, one-cycle pulse per word
imem_addr   output  ADDR_WIDTH  word address for the write
imem_wdata  output  32  instruction word for the write
cpu_hold    output  1   high: hold program_counter and if_id (drives pc_write/if_id_write low)
pc_clear    output  1   one-cycle pulse that zeroes the program counter when the load completes
load_done   output  1   image loaded and checksum matched; sticky until reset
load_err    output  1   length overflow or checksum mismatch; sticky until reset

Behaviour:
- Reset values: state=LEN, byte_cnt=0, word_cnt=0, csum=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, pc_clear=0, load_done=0, load_err=0.
- Frame format:
  - 4 length bytes, MSB first: N = number of words.
  - N words of 4 bytes each, MSB first.
  - 1 checksum byte = XOR of all 4N data bytes. Length bytes are excluded.
- byte_ready is a combinational function of state only: 1 in LEN, DATA, CSUM; 0 in DONE and ERR.
- A transfer with byte_valid low consumes nothing; valid gaps of any length are legal.
- byte_cnt (2 bits) counts accepted bytes within the current field and wraps 3→0.
- State LEN:
  - Shift each accepted byte into the length register.
  - On the 4th byte:
    - If N > 2^ADDR_WIDTH - BASE_ADDR, go to ERR.
    - Else if N == 0, go to CSUM.
    - Else go to DATA.
- State DATA:
  - Shift each accepted byte into the word register and XOR it into csum.
  - On the 4th byte of a word, in the next cycle: imem_we=1, imem_wdata=assembled word, imem_addr=BASE_ADDR+word_cnt. imem_we is 0 in every other cycle.
  - word_cnt increments on that 4th byte.
  - When word_cnt reaches N, go to CSUM.
  - A new byte may be accepted in the same cycle as the imem_we pulse, so full throughput is 1 byte/cycle.
- State CSUM:
  - Accept one byte. If it equals csum, go to DONE; else go to ERR.
  - The final imem_we pulse may coincide with the cycle the checksum byte is accepted.
- DONE:
  - load_done=1, cpu_hold=0.
  - pc_clear=1 for exactly the first cycle in DONE.
  - Remain in DONE until reset.
- ERR:
  - load_err=1, cpu_hold stays 1, byte_ready=0.
  - Remain in ERR until reset.
  - Words already written are not erased.
- cpu_hold is 1 in every state except DONE.
- imem_addr arithmetic is modulo 2^ADDR_WIDTH. The overflow check guarantees no wrap for accepted images.
- Reset mid-operation:
  - Returns to the reset values above in the same edge.
  - Any pending imem_we is dropped.
  - A partially assembled word is discarded.
  - A reset asserted in the same cycle as a transfer wins; the byte is lost.

Test Plan:
- Two-word load:
  - Stimulus: stream 00 00 00 02 | 20 08 00 05 | 20 09 00 0A | 0E, byte_valid held high.
  - Required: imem_we pulses write 0x20080005@0 and 0x2009000A@1; load_done=1, load_err=0.
  - Required: pc_clear high for exactly 1 cycle; cpu_hold falls in that same cycle; byte_ready=0 afterwards.
- Zero-length image:
  - Stimulus: 00 00 00 00 | 00.
  - Required: no imem_we; DONE reached. A trailing byte 01 instead of 00 → load_err=1, cpu_hold=1.
- Bad checksum:
  - Stimulus: two-word frame above with checksum 0F.
  - Required: both words still written; load_err=1, load_done=0, cpu_hold=1, byte_ready=0.
- Length overflow:
  - Stimulus: ADDR_WIDTH=18, BASE_ADDR=0, length 00 04 00 01.
  - Required: ERR right after the 4th length byte; zero imem_we pulses.
  - Required: with length 00 04 00 00, LEN is accepted and the loader enters DATA.
- Handshake gaps:
  - Stimulus: two-word frame with byte_valid deasserted for 3 cycles between every byte.
  - Required: identical writes, addresses and final flags as the back-to-back case; no write triggered during gaps.
- Reset mid-load:
  - Stimulus: assert reset after byte 2 of word 1, then stream a fresh one-word frame 00 00 00 01 | DE AD BE EF | 22.
  - Required: only 0xDEADBEEF@0 is written; load_done=1.
